// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - ALU control codes (1..19) as produced by the ALU control decoder
//   - FSM state type and shift-kind type
//   - helpers: is_shift(), is_legal(), shift_kind()
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_ADDI  = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_ORI   = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_XORI  = 5'd6;
  localparam logic [4:0] ALU_AND   = 5'd7;
  localparam logic [4:0] ALU_ANDI  = 5'd8;
  localparam logic [4:0] ALU_SUB   = 5'd9;
  localparam logic [4:0] ALU_SLT   = 5'd10;
  localparam logic [4:0] ALU_SLTI  = 5'd11;
  localparam logic [4:0] ALU_SLTU  = 5'd12;
  localparam logic [4:0] ALU_SLTIU = 5'd13;
  localparam logic [4:0] ALU_SLLI  = 5'd14;
  localparam logic [4:0] ALU_SRLI  = 5'd15;
  localparam logic [4:0] ALU_SRAI  = 5'd16;
  localparam logic [4:0] ALU_SLL   = 5'd17;
  localparam logic [4:0] ALU_SRL   = 5'd18;
  localparam logic [4:0] ALU_SRA   = 5'd19;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_t;

  function automatic logic is_shift(input logic [4:0] code);
    return (code >= ALU_SLLI) && (code <= ALU_SRA);
  endfunction

  function automatic logic is_legal(input logic [4:0] code);
    return (code != 5'd0) && (code <= ALU_SRA);
  endfunction

  function automatic sh_kind_t shift_kind(input logic [4:0] code);
    case (code)
      ALU_SRLI, ALU_SRL: return SH_RL;
      ALU_SRAI, ALU_SRA: return SH_RA;
      default:           return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative one-bit-per-cycle shifter.
//   start    - load data_in/shamt/kind (shamt must be non-zero)
//   busy     - shift in progress
//   done     - combinational, high in the final shift cycle
//   data_out - value after this cycle's shift step (final value when done)
// Only built when FAST_SHIFT_EN is undefined; the fast build shifts
// combinationally inside alu_exec_unit.
`ifndef FAST_SHIFT_EN
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  sh_kind_t           kind,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    data_out
);

  logic [XLEN-1:0]    sh_q, step;
  logic [SHAMT_W-1:0] cnt_q;
  sh_kind_t           kind_q;

  always_comb begin
    step = sh_q;
    case (kind_q)
      SH_LL:   step = {sh_q[XLEN-2:0], 1'b0};
      SH_RL:   step = {1'b0, sh_q[XLEN-1:1]};
      SH_RA:   step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: step = sh_q;
    endcase
  end

  // The last step is taken combinationally so the owner can load it on the
  // same edge that ends the shift.
  assign done     = busy && (cnt_q == SHAMT_W'(1));
  assign data_out = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
      busy   <= 1'b0;
    end else if (start) begin
      sh_q   <= data_in;
      cnt_q  <= shamt;
      kind_q <= kind;
      busy   <= 1'b1;
    end else if (busy) begin
      sh_q  <= step;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready on both sides.
//   in_valid/in_ready/alu_ctrl/op_a/op_b - upstream op
//   out_valid/out_ready/result/zero/illegal - registered result
//   busy - iterative shift in progress
// Build option FAST_SHIFT_EN: barrel shifter, every op single-cycle,
// no SHIFT state, busy tied low. Results are identical in both builds.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  logic [SHAMT_W-1:0] shamt;
  logic               accept, load, load_ill, lt_s, lt_u;
  logic [XLEN-1:0]    single_val, load_val;

  assign shamt  = op_b[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;
  assign lt_s   = $signed(op_a) < $signed(op_b);
  assign lt_u   = op_a < op_b;

  // Single-cycle result; illegal codes fall through to zero.
  always_comb begin
    single_val = '0;
    case (alu_ctrl)
      ALU_ADD,  ALU_ADDI:  single_val = op_a + op_b;
      ALU_SUB:             single_val = op_a - op_b;
      ALU_OR,   ALU_ORI:   single_val = op_a | op_b;
      ALU_XOR,  ALU_XORI:  single_val = op_a ^ op_b;
      ALU_AND,  ALU_ANDI:  single_val = op_a & op_b;
      ALU_SLT,  ALU_SLTI:  single_val = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU, ALU_SLTIU: single_val = {{(XLEN-1){1'b0}}, lt_u};
`ifdef FAST_SHIFT_EN
      ALU_SLLI, ALU_SLL:   single_val = op_a << shamt;
      ALU_SRLI, ALU_SRL:   single_val = op_a >> shamt;
      ALU_SRAI, ALU_SRA:   single_val = $signed(op_a) >>> shamt;
`else
      // Only shamt == 0 reaches the single-cycle path here.
      ALU_SLLI, ALU_SLL, ALU_SRLI, ALU_SRL,
      ALU_SRAI, ALU_SRA:   single_val = op_a;
`endif
      default:             single_val = '0;
    endcase
  end

`ifdef FAST_SHIFT_EN
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;

  always_comb begin
    load     = accept;
    load_val = single_val;
    load_ill = !is_legal(alu_ctrl);
  end
`else
  state_t          state_q, state_d;
  logic            sh_start, sh_done;
  logic [XLEN-1:0] sh_out;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sh_start = 1'b0;
    load     = 1'b0;
    load_val = single_val;
    load_ill = !is_legal(alu_ctrl);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift(alu_ctrl) && (shamt != '0)) begin
            sh_start = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // alu_ctrl no longer belongs to this op; a shift is always legal.
        load_ill = 1'b0;
        load_val = sh_out;
        if (sh_done) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sh_start),
    .kind     (shift_kind(alu_ctrl)),
    .data_in  (op_a),
    .shamt    (shamt),
    .busy     (busy),
    .done     (sh_done),
    .data_out (sh_out)
  );
`endif

  // Output register: a new result may load in the same cycle the previous
  // one drains, otherwise out_valid drops after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      result    <= load_val;
      zero      <= (load_val == '0);
      illegal   <= load_ill;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
